// File: rtl/note_player.sv
// -----------------------------------------------------------------------------
// note_player
// Per-channel playback stage. Requests one note at a time from the pattern
// sequencer, latches the returned pitch/length/instrument and times the note
// in frame ticks, driving gate/trigger/pitch/instrument to the voice stage.
//
// Parameters:
//   RELEASE_TICKS  gate drops when this many ticks of the note remain (0..31)
//   TIMEOUT        max cycles in WAIT_NOTE without a valid note (1..255)
//
// Ports:
//   i_clk              clock
//   i_rst_n            asynchronous active-low reset
//   i_enable           playback enable (level)
//   i_tick             frame tick strobe (one cycle)
//   o_note_stb         next-note request pulse to the sequencer
//   i_note_valid       note data valid pulse
//   i_note_pitch       pitch, 0 = rest
//   i_note_len         duration code, duration = len+1 ticks
//   i_note_instrument  instrument select
//   o_pitch            latched pitch of the current note
//   o_instrument       latched instrument of the current note
//   o_gate             note sounding
//   o_trigger          one-cycle pulse at the start of a non-rest note
//   o_busy             state is not IDLE
//   o_error            sticky sequencer-timeout fault
// -----------------------------------------------------------------------------
module note_player #(
    parameter int RELEASE_TICKS = 1,
    parameter int TIMEOUT       = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_tick,
    output logic       o_note_stb,
    input  logic       i_note_valid,
    input  logic [5:0] i_note_pitch,
    input  logic [4:0] i_note_len,
    input  logic [3:0] i_note_instrument,
    output logic [5:0] o_pitch,
    output logic [3:0] o_instrument,
    output logic       o_gate,
    output logic       o_trigger,
    output logic       o_busy,
    output logic       o_error
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQUEST   = 2'd1,
        S_WAIT_NOTE = 2'd2,
        S_PLAYING   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [5:0] RELEASE_CMP  = 6'(RELEASE_TICKS);

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_remain;
    logic [5:0] w_remain_next;
    logic       r_pending;
    logic       w_pending_next;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_next;
    logic [5:0] r_pitch;
    logic [5:0] w_pitch_next;
    logic [3:0] r_instrument;
    logic [3:0] w_instrument_next;
    logic       r_trigger;
    logic       w_trigger_next;
    logic       r_error;
    logic       w_error_next;

    // Tick seen in the same cycle as the note data still counts as pending.
    logic       w_tick_pending;
    logic [5:0] w_len_full;
    logic [5:0] w_len_short;

    assign w_tick_pending = r_pending | i_tick;
    assign w_len_full     = {1'b0, i_note_len} + 6'd1;
    // A pending tick already consumed one tick of the note, but a note always
    // lasts at least one more tick so the counter never loads 0.
    assign w_len_short    = (i_note_len == 5'd0) ? 6'd1 : {1'b0, i_note_len};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_remain     <= 6'd0;
            r_pending    <= 1'b0;
            r_wait_cnt   <= 8'd0;
            r_pitch      <= 6'd0;
            r_instrument <= 4'd0;
            r_trigger    <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_remain     <= w_remain_next;
            r_pending    <= w_pending_next;
            r_wait_cnt   <= w_wait_cnt_next;
            r_pitch      <= w_pitch_next;
            r_instrument <= w_instrument_next;
            r_trigger    <= w_trigger_next;
            r_error      <= w_error_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_remain_next     = r_remain;
        w_pending_next    = r_pending;
        w_wait_cnt_next   = r_wait_cnt;
        w_pitch_next      = r_pitch;
        w_instrument_next = r_instrument;
        w_trigger_next    = 1'b0;
        w_error_next      = r_error;

        case (r_state)
            S_IDLE: begin
                if (i_enable && !r_error) begin
                    w_state_next = S_REQUEST;
                end
            end

            S_REQUEST: begin
                if (i_tick) begin
                    w_pending_next = 1'b1;
                end
                w_wait_cnt_next = 8'd0;
                w_state_next    = S_WAIT_NOTE;
            end

            S_WAIT_NOTE: begin
                // Valid has priority over a coincident timeout.
                if (i_note_valid) begin
                    w_pitch_next      = i_note_pitch;
                    w_instrument_next = i_note_instrument;
                    w_remain_next     = w_tick_pending ? w_len_short : w_len_full;
                    w_pending_next    = 1'b0;
                    w_trigger_next    = (i_note_pitch != 6'd0);
                    w_state_next      = S_PLAYING;
                end else begin
                    w_pending_next = w_tick_pending;
                    if (r_wait_cnt == TIMEOUT_LAST) begin
                        w_error_next   = 1'b1;
                        w_pending_next = 1'b0;
                        w_state_next   = S_IDLE;
                    end else begin
                        w_wait_cnt_next = r_wait_cnt + 8'd1;
                    end
                end
            end

            S_PLAYING: begin
                if (i_tick) begin
                    if (r_remain <= 6'd1) begin
                        w_state_next = i_enable ? S_REQUEST : S_IDLE;
                    end else begin
                        w_remain_next = r_remain - 6'd1;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_note_stb   = (r_state == S_REQUEST);
    assign o_busy       = (r_state != S_IDLE);
    assign o_gate       = (r_state == S_PLAYING) && (r_pitch != 6'd0) && (r_remain > RELEASE_CMP);
    assign o_trigger    = r_trigger;
    assign o_error      = r_error;
    assign o_pitch      = r_pitch;
    assign o_instrument = r_instrument;

endmodule

// File: doc/note_player.md
# note_player

Per-channel playback stage directly downstream of the pattern sequencer. It requests one note at a time through a strobe. It latches the returned pitch, length and instrument, and times the note in frame ticks. It drives the gate, trigger and pitch/instrument controls consumed by the voice/oscillator stage.

## Interface
- `RELEASE_TICKS`, default 1: the gate drops when this many ticks of the note remain (range 0..31).
- `TIMEOUT`, default 15: maximum cycles spent in WAIT_NOTE without `i_note_valid` before a fault (range 1..255).
- `i_clk`  in  1  single clock domain.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_enable`  in  1  playback enable (level).
- `i_tick`  in  1  frame tick strobe; one cycle wide; at least 16 cycles apart.
- `o_note_stb`  out  1  next-note request to the sequencer; one-cycle pulse.
- `i_note_valid`  in  1  note data valid; one-cycle pulse.
- `i_note_pitch`  in  6  pitch; 0 = rest.
- `i_note_len`  in  5  duration code; duration = `i_note_len`+1 ticks (1..32).
- `i_note_instrument`  in  4  instrument select.
- `o_pitch`  out  6  latched pitch of the current note.
- `o_instrument`  out  4  latched instrument of the current note.
- `o_gate`  out  1  note sounding.
- `o_trigger`  out  1  one-cycle pulse at the start of a non-rest note.
- `o_busy`  out  1  state ≠ IDLE.
- `o_error`  out  1  sticky sequencer-timeout fault.

## Operation
- States:
  - IDLE: if `i_enable` & !`o_error` → REQUEST.
  - REQUEST: `o_note_stb`=1 for this single cycle → WAIT_NOTE.
  - WAIT_NOTE:
    - On `i_note_valid`: latch all three note fields, load the counter → PLAYING.
    - If the wait count reaches `TIMEOUT` first: set `o_error`, go to IDLE.
  - PLAYING:
    - Each `i_tick` decrements `remain`.
    - A tick seen while `remain`==1 ends the note: if `i_enable` → REQUEST, else IDLE.
- Counter `remain` is 6 bits, loaded with `i_note_len`+1. No wrap; it never decrements below 1.
- Pending tick:
  - A single `pending` flag records any `i_tick` seen in REQUEST or WAIT_NOTE.
  - On load with `pending` set, `remain` = max(`i_note_len`,1) and `pending` clears.
  - Ticks in IDLE are discarded.
- Gate: `o_gate` = (state==PLAYING) & (`o_pitch`≠0) & (`remain` > `RELEASE_TICKS`).
  - A note whose duration ≤ `RELEASE_TICKS` produces a trigger but no gate.
- Trigger: `o_trigger`=1 on the first PLAYING cycle, only if the latched pitch ≠ 0.
- `o_pitch`/`o_instrument` hold their values after the note ends, until the next latch.
- `i_note_valid` outside WAIT_NOTE is ignored; nothing is latched.
- `i_enable` low mid-note: the current note plays to completion, then IDLE. Raising it again in IDLE restarts requests.
- `o_error` clears only by reset. While set, the block stays in IDLE.
- Wait-cycle counter: 8 bits, cleared on entry to WAIT_NOTE.

## Timing
- Reset (async assert, sync release): state IDLE; `o_note_stb`, `o_gate`, `o_trigger`, `o_busy`, `o_error` = 0; `o_pitch`, `o_instrument`, `remain`, `pending` = 0.
- All outputs are registered or decoded from registered state; there are no combinational input→output paths.
- Request latency:
  - `i_enable` sampled high in IDLE at cycle N → `o_note_stb` high at cycle N+1.
  - Note ends at cycle N → `o_note_stb` high at N+1.
- Note start: `i_note_valid` sampled at cycle M → PLAYING, `o_pitch`, `o_gate` and `o_trigger` valid at M+1.
- Timeout: WAIT_NOTE entered at cycle W with no valid → `o_error` high and IDLE at W+`TIMEOUT`.
- Simultaneous `i_note_valid` and timeout in the same cycle: valid wins, no error.
- Simultaneous `i_tick` and `i_note_valid` in WAIT_NOTE: the tick counts as pending.
- Gate release timing:
  - Sounding duration = `i_note_len`+1−`RELEASE_TICKS` ticks.
  - Gate falls in the cycle after the tick that makes `remain`==`RELEASE_TICKS`.
- The sequencer returns data 3–5 cycles after the strobe, so the default `TIMEOUT` of 15 leaves margin.

## Test plan
- Reset, then `i_enable`=1; respond to the strobe 4 cycles later with pitch 12, len 3, instrument 5.
  - Trigger pulses once.
  - `o_gate` is high for 3 ticks.
  - Next strobe comes one cycle after the 4th tick.
- Rest: pitch 0, len 1 → no trigger, `o_gate` stays 0, next strobe after 2 ticks.
- Pending tick: `i_tick` between the strobe and valid, len 4 → note ends on the 4th subsequent tick.
- Pending tick with len 0 → note ends on the first subsequent tick.
- Never assert valid → `o_error`=1 exactly 15 cycles after entering WAIT_NOTE.
  - Afterwards: no more strobes, `o_busy`=0.
  - `i_rst_n` low clears the error.
- Drop `i_enable` mid-note → the note completes, no strobe, `o_busy` falls. Asserting `i_rst_n` mid-PLAYING immediately zeroes `o_gate` and `o_busy`.
